pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It sits beside id_stage and reads the decoded register addresses from ID plus load, multiply/divide (MDU) and branch status from EX. It generates stall, flush and bubble (no_op_flag) controls plus the PC redirect select. It also keeps saturating performance counters for stall and flush events.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
// Imported by the controller and its perf-counter sub-module.
package pipeline_ctrl_pkg;

    localparam int MDU_MAX_CYCLES_DEF = 34;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the stall and flush performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_o <= '0;
        else if (inc_i && (count_o != '1))
            count_o <= count_o + WIDTH'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: load-use stall, jump/branch redirect,
// MDU wait with timeout, and saturating stall/flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH      = 32,
    parameter int MDU_MAX_CYCLES = MDU_MAX_CYCLES_DEF,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  id_jump_i,
    input  logic                  ex_load_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_mdu_start_i,
    input  logic                  mdu_done_i,
    input  logic                  ex_branch_taken_i,
    output logic [1:0]            pc_sel_o,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_bubble_o,
    output logic                  ex_mem_bubble_o,
    output logic                  mdu_err_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    localparam int WAIT_W = $clog2(MDU_MAX_CYCLES);

    pctrl_state_t      state;
    pctrl_state_t      state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err;
    logic              hazard;
    logic              waiting;
    logic              timeout;
    pc_sel_t           sel;

    assign hazard = ex_load_i && (ex_rd_addr_i != '0) &&
                    ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    // Once done is seen the stall drops and the RUN rules apply that cycle.
    assign waiting = (state == MDU_WAIT) && !mdu_done_i;
    assign timeout = waiting && (wait_cnt == WAIT_W'(MDU_MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (ex_mdu_start_i && !mdu_done_i && !ex_branch_taken_i)
                    state_next = MDU_WAIT;
            end
            MDU_WAIT: begin
                if (mdu_done_i || timeout)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state == RUN)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout)
                err <= 1'b1;
        end
    end

    always_comb begin
        sel             = PC_PLUS4;
        pc_stall_o      = 1'b0;
        if_id_stall_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        if (rst_n) begin
            if (waiting) begin
                pc_stall_o      = 1'b1;
                if_id_stall_o   = 1'b1;
                ex_mem_bubble_o = 1'b1;
            end else if (ex_branch_taken_i) begin
                sel            = PC_BRANCH;
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end else if (hazard) begin
                // JALR may read the loaded register, so the jump waits too.
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end else if (id_jump_i) begin
                sel           = PC_JUMP;
                if_id_flush_o = 1'b1;
            end
        end
    end

    assign pc_sel_o  = sel;
    assign mdu_err_o = err;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (pc_stall_o),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (if_id_flush_o),
        .count_o (flush_cnt_o)
    );

    a_branch_mdu: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_branch_taken_i && ex_mdu_start_i));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the hazard/MDU rules.
module tb_pipeline_ctrl;

    localparam int CW   = 4;
    localparam int MAXC = 34;
    localparam int AW   = 5;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rs1, rs2, rd;
    logic          u1, u2, jump, load, start, done, branch;
    logic [1:0]    pc_sel;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_bubble;
    logic          mdu_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic [1:0]    sel;
        logic          stall;
        logic          ifs;
        logic          flush;
        logic          idb;
        logic          exb;
        logic          err;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    bit m_busy;
    int m_wait;
    bit m_err;
    int m_stalls;
    int m_flushes;

    pipeline_ctrl #(.CNT_WIDTH(CW), .MDU_MAX_CYCLES(MAXC), .REG_ADDR_W(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1_addr_i     (rs1),
        .id_rs2_addr_i     (rs2),
        .id_rs1_used_i     (u1),
        .id_rs2_used_i     (u2),
        .id_jump_i         (jump),
        .ex_load_i         (load),
        .ex_rd_addr_i      (rd),
        .ex_mdu_start_i    (start),
        .mdu_done_i        (done),
        .ex_branch_taken_i (branch),
        .pc_sel_o          (pc_sel),
        .pc_stall_o        (pc_stall),
        .if_id_stall_o     (if_id_stall),
        .if_id_flush_o     (if_id_flush),
        .id_ex_bubble_o    (id_ex_bubble),
        .ex_mem_bubble_o   (ex_mem_bubble),
        .mdu_err_o         (mdu_err),
        .stall_cnt_o       (stall_cnt),
        .flush_cnt_o       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_sel", 32'(pc_sel), 32'(e.sel));
            chk("pc_stall", 32'(pc_stall), 32'(e.stall));
            chk("if_id_stall", 32'(if_id_stall), 32'(e.ifs));
            chk("if_id_flush", 32'(if_id_flush), 32'(e.flush));
            chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.idb));
            chk("ex_mem_bubble", 32'(ex_mem_bubble), 32'(e.exb));
            chk("mdu_err", 32'(mdu_err), 32'(e.err));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
            chk("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
        end
    end

    task automatic clr();
        rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0;
        jump = 0; load = 0; start = 0; done = 0; branch = 0;
    endtask

    // One clock cycle: apply rst level, predict the outputs, advance.
    task automatic cycle(input logic r);
        exp_t e;
        bit   hz;
        rst_n = r;
        e = '0;
        if (!r) begin
            m_busy = 0; m_wait = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            e.err  = m_err;
            e.scnt = CW'(m_stalls);
            e.fcnt = CW'(m_flushes);
            hz = load && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            if (m_busy && !done) begin
                e.stall = 1; e.ifs = 1; e.exb = 1;
            end else if (branch) begin
                e.sel = 2; e.flush = 1; e.idb = 1;
            end else if (hz) begin
                e.stall = 1; e.ifs = 1; e.idb = 1;
            end else if (jump) begin
                e.sel = 1; e.flush = 1;
            end
            if (m_busy) begin
                if (done) m_busy = 0;
                else if (m_wait == MAXC - 1) begin m_err = 1; m_busy = 0; end
                else m_wait++;
            end else if (start && !done && !branch) begin
                m_busy = 1; m_wait = 0;
            end
            if (e.stall && m_stalls < SAT) m_stalls++;
            if (e.flush && m_flushes < SAT) m_flushes++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [AW-1:0] r, input bit on_rs1);
        load = 1; rd = r;
        if (on_rs1) begin rs1 = r; u1 = 1; end
        else begin rs2 = r; u2 = 1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr();
        @(posedge clk);
        #1;
        cycle(0);
        clr(); cycle(1);

        load_use(5'd5, 0); cycle(1);
        clr(); cycle(1);
        load_use(5'd0, 0); cycle(1);
        clr(); cycle(1);

        jump = 1; cycle(1);
        load_use(5'd7, 1); cycle(1);
        clr(); jump = 1; cycle(1);
        clr(); cycle(1);

        load_use(5'd9, 0); branch = 1; cycle(1);
        clr(); cycle(1);

        cycle(0);
        clr(); start = 1; cycle(1);
        clr(); repeat (10) cycle(1);
        done = 1; cycle(1);
        clr(); cycle(1);
        start = 1; done = 1; cycle(1);
        clr(); repeat (2) cycle(1);

        cycle(0);
        clr(); start = 1; cycle(1);
        clr(); repeat (MAXC + 3) cycle(1);
        jump = 1; cycle(1);
        clr(); cycle(1);
        cycle(0);
        cycle(1);

        start = 1; cycle(1);
        clr(); repeat (3) cycle(1);
        cycle(0);
        repeat (2) cycle(1);

        load_use(5'd3, 1); repeat (20) cycle(1);
        clr(); cycle(1);

        for (int i = 0; i < 2000; i++) begin
            rs1    = AW'($urandom_range(0, 7));
            rs2    = AW'($urandom_range(0, 7));
            rd     = AW'($urandom_range(0, 7));
            u1     = 1'($urandom_range(0, 1));
            u2     = 1'($urandom_range(0, 1));
            load   = ($urandom_range(0, 2) == 0);
            branch = ($urandom_range(0, 7) == 0);
            jump   = ($urandom_range(0, 5) == 0);
            start  = !m_busy && !branch && !load && ($urandom_range(0, 9) == 0);
            done   = m_busy ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 19) == 0);
            cycle(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
        end

        clr();
        cycle(1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
